// File: rtl/dmem_arb_pkg.sv
// dmem_arbiter shared types: FSM states, owner select, latched request.
// Widths here are the defaults used by the interfaces and the top.
package dmem_arb_pkg;

  localparam int DMEM_ADDR_W = 7;
  localparam int DMEM_DATA_W = 32;
  localparam int STARVE_W = 8;
  localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    RESP
  } arb_state_e;

  typedef enum logic {
    OWN_CPU,
    OWN_DBG
  } owner_e;

  typedef struct packed {
    logic                   we;
    logic [DMEM_ADDR_W-1:0] addr;
    logic [DMEM_DATA_W-1:0] wdata;
  } mem_req_t;

  function automatic logic misaligned(
    input logic [1:0] a
  );
    return (a & WORD_ALIGN_MASK) != 2'b00;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester bus (CPU / DBG) and data-memory bus for dmem_arbiter.
// master = side that drives the request / the memory command.
interface dmem_req_if
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = DMEM_ADDR_W,
  parameter int DATA_W = DMEM_DATA_W
) ();
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              done;
  logic              err;

  modport master (
    output req, we, addr, wdata,
    input  rdata, done, err
  );
  modport slave (
    input  req, we, addr, wdata,
    output rdata, done, err
  );
endinterface

interface dmem_mem_if
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = DMEM_ADDR_W,
  parameter int DATA_W = DMEM_DATA_W
) ();
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              re;
  logic              we;
  logic [DATA_W-1:0] rdata;

  modport master (
    output addr, wdata, re, we,
    input  rdata
  );
  modport slave (
    input  addr, wdata, re, we,
    output rdata
  );
endinterface

// File: rtl/dmem_arb_starve_ctr.sv
// Saturating DBG starvation counter; a DBG grant clears it.
// sat_o forces DBG to top priority at the next IDLE decision.
module dmem_arb_starve_ctr
  import dmem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic dbg_req_i,
  input  logic dbg_busy_i,
  input  logic grant_i,
  output logic sat_o
);

  localparam logic [STARVE_W-1:0] MAX_C =
    STARVE_W'(STARVE_MAX);

  logic [STARVE_W-1:0] cnt_q, cnt_d;
  logic inc;

  assign inc = dbg_req_i & ~dbg_busy_i &
               ~grant_i & (cnt_q != MAX_C);
  assign sat_o = (cnt_q == MAX_C);

  always_comb begin
    cnt_d = cnt_q;
    unique case (1'b1)
      grant_i: cnt_d = '0;
      inc:     cnt_d = cnt_q + 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// CPU/DBG data-memory arbiter: fixed-latency sequencing, stall, starvation guard.
// Optional perf counters enabled by defining DMEM_ARB_PERF_EN.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W     = DMEM_ADDR_W,
  parameter int DATA_W     = DMEM_DATA_W,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 8
) (
  input  logic        clk,
  input  logic        reset,
  dmem_req_if.slave   cpu,
  dmem_req_if.slave   dbg,
  dmem_mem_if.master  mem,
  output logic        cpu_stall_o
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [31:0] perf_cpu_stall_cyc_o,
  output logic [15:0] perf_dbg_grants_o
`endif
);

  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  arb_state_e        state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [3:0]        cnt_q, cnt_d;
  mem_req_t          req_q, req_d, sel_req;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] sel_addr;
  logic              dbg_sel, dbg_grant;
  logic              dbg_busy, starve_sat;

  dmem_arb_starve_ctr #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve (
    .clk       (clk),
    .reset     (reset),
    .dbg_req_i (dbg.req),
    .dbg_busy_i(dbg_busy),
    .grant_i   (dbg_grant),
    .sat_o     (starve_sat)
  );

  assign dbg_sel   = (starve_sat & dbg.req) | ~cpu.req;
  assign dbg_grant = (state_q == IDLE) & dbg.req & dbg_sel;
  assign dbg_busy  = (state_q != IDLE) &
                     (owner_q == OWN_DBG);
  assign sel_addr  = dbg_sel ? dbg.addr : cpu.addr;

  always_comb begin
    sel_req = '{we: cpu.we, addr: sel_addr,
                wdata: cpu.wdata};
    if (dbg_sel) begin
      sel_req.we    = dbg.we;
      sel_req.wdata = dbg.wdata;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    req_d     = req_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    mem.addr  = '0;
    mem.wdata = '0;
    mem.re    = 1'b0;
    mem.we    = 1'b0;
    cpu.done  = 1'b0;
    cpu.err   = 1'b0;
    cpu.rdata = '0;
    dbg.done  = 1'b0;
    dbg.err   = 1'b0;
    dbg.rdata = '0;
    unique case (state_q)
      IDLE: begin
        if (cpu.req | dbg.req) begin
          owner_d = dbg_sel ? OWN_DBG : OWN_CPU;
          req_d   = sel_req;
          rdata_d = '0;
          // misaligned: respond at once, no memory cycle
          if (misaligned(sel_addr[1:0])) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            err_d   = 1'b0;
            cnt_d   = LAT_M1;
            state_d = ACC;
          end
        end
      end
      ACC: begin
        mem.addr  = req_q.addr;
        mem.wdata = req_q.wdata;
        mem.re    = ~req_q.we;
        mem.we    = req_q.we & (cnt_q == '0);
        if (cnt_q == '0) begin
          if (!req_q.we) rdata_d = mem.rdata;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (owner_q == OWN_DBG) begin
          dbg.done  = 1'b1;
          dbg.err   = err_q;
          dbg.rdata = rdata_q;
        end else begin
          cpu.done  = 1'b1;
          cpu.err   = err_q;
          cpu.rdata = rdata_q;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= OWN_CPU;
      cnt_q   <= '0;
      req_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign cpu_stall_o = cpu.req & ~cpu.done;

`ifdef DMEM_ARB_PERF_EN
  logic [31:0] perf_stall_q;
  logic [15:0] perf_dbg_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_q <= '0;
      perf_dbg_q   <= '0;
    end else begin
      if (cpu_stall_o) perf_stall_q <= perf_stall_q + 32'd1;
      if (dbg_grant)   perf_dbg_q   <= perf_dbg_q + 16'd1;
    end
  end

  assign perf_cpu_stall_cyc_o = perf_stall_q;
  assign perf_dbg_grants_o    = perf_dbg_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: vector table, contention/reset
// sequences, and random single-port traffic against a word-array model.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int MEM_LAT = 2;
  localparam int STARVE_MAX = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cpu_stall;
`ifdef DMEM_ARB_PERF_EN
  logic [31:0] perf_stall;
  logic [15:0] perf_dbg;
`endif

  dmem_req_if #(.ADDR_W(7), .DATA_W(32)) cpu_if ();
  dmem_req_if #(.ADDR_W(7), .DATA_W(32)) dbg_if ();
  dmem_mem_if #(.ADDR_W(7), .DATA_W(32)) mem_if ();

  dmem_arbiter #(
    .ADDR_W(7), .DATA_W(32),
    .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .reset(reset),
    .cpu(cpu_if), .dbg(dbg_if), .mem(mem_if),
    .cpu_stall_o(cpu_stall)
`ifdef DMEM_ARB_PERF_EN
    , .perf_cpu_stall_cyc_o(perf_stall),
    .perf_dbg_grants_o(perf_dbg)
`endif
  );

  always #5 clk = ~clk;

  // memory array behind the arbiter
  logic [31:0] tb_mem [32];
  assign mem_if.rdata = tb_mem[mem_if.addr[6:2]];
  always @(posedge clk)
    if (mem_if.we) tb_mem[mem_if.addr[6:2]] <= mem_if.wdata;

  // reference contents
  logic [31:0] ref_mem [32];

  int n_pass = 0;
  int n_tot = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic logic [31:0] pat(input int i);
    return {8'hA5, 8'(i), ~8'(i), 8'(i * 7)};
  endfunction

  int          r_lat [2];
  logic [31:0] r_rd [2];
  logic        r_err [2];
  int          we_cnt, we_cyc, re_cnt, spur;
  logic [6:0]  we_addr;
  logic [31:0] we_data;
  logic [15:0] stall_mask;

  task automatic xfer2(
    input bit ce, input bit cwe, input logic [6:0] ca,
    input logic [31:0] cd,
    input bit de, input bit dwe, input logic [6:0] da,
    input logic [31:0] dd);
    bit pc, pd;
    @(negedge clk);
    cpu_if.req = ce; cpu_if.we = cwe;
    cpu_if.addr = ca; cpu_if.wdata = cd;
    dbg_if.req = de; dbg_if.we = dwe;
    dbg_if.addr = da; dbg_if.wdata = dd;
    pc = ce; pd = de;
    r_lat[0] = 0; r_lat[1] = 0;
    r_rd[0] = '0; r_rd[1] = '0;
    r_err[0] = 1'b0; r_err[1] = 1'b0;
    we_cnt = 0; we_cyc = 0; re_cnt = 0; spur = 0;
    we_addr = '0; we_data = '0; stall_mask = '0;
    #1 stall_mask[0] = cpu_stall;
    for (int k = 1; k <= 40 && (pc || pd); k++) begin
      @(negedge clk);
      if (k < 16) stall_mask[k] = cpu_stall;
      if (mem_if.re) re_cnt++;
      if (mem_if.we) begin
        we_cnt++; we_cyc = k;
        we_addr = mem_if.addr; we_data = mem_if.wdata;
      end
      if (cpu_if.done) begin
        if (pc) begin
          r_lat[0] = k; r_rd[0] = cpu_if.rdata;
          r_err[0] = cpu_if.err; pc = 0; cpu_if.req = 1'b0;
        end else spur++;
      end
      if (dbg_if.done) begin
        if (pd) begin
          r_lat[1] = k; r_rd[1] = dbg_if.rdata;
          r_err[1] = dbg_if.err; pd = 0; dbg_if.req = 1'b0;
        end else spur++;
      end
    end
    chk("xfer_complete", {30'd0, pc, pd}, 32'd0);
  endtask

  task automatic run_one(input bit port, input bit we,
                         input logic [6:0] a, input logic [31:0] wd);
    if (port) xfer2(0, 0, 7'h0, 0, 1, we, a, wd);
    else      xfer2(1, we, a, wd, 0, 0, 7'h0, 0);
  endtask

  task automatic check_one(
    input string nm, input bit port, input bit we,
    input logic [6:0] a, input logic [31:0] wd,
    input logic [31:0] erd, input bit eerr, input int elat);
    bit acc;
    acc = !eerr;
    chk({nm, "_lat"}, r_lat[port], elat);
    chk({nm, "_err"}, 32'(r_err[port]), 32'(eerr));
    if (!we) chk({nm, "_rdata"}, r_rd[port], erd);
    chk({nm, "_we_cnt"}, we_cnt, (we && acc) ? 1 : 0);
    chk({nm, "_re_cnt"}, re_cnt, (!we && acc) ? MEM_LAT : 0);
    chk({nm, "_stall"}, 32'(stall_mask),
        port ? 32'd0 : 32'((1 << elat) - 1));
    chk({nm, "_spurious_done"}, spur, 0);
    if (we && acc) begin
      chk({nm, "_we_cyc"}, we_cyc, MEM_LAT);
      chk({nm, "_we_addr"}, 32'(we_addr), 32'(a));
      chk({nm, "_we_data"}, we_data, wd);
    end
  endtask

  // word-level model: alignment rule, fixed latency, memory contents
  task automatic model(input bit we, input logic [6:0] a,
                       input logic [31:0] wd,
                       output logic [31:0] erd, output bit eerr,
                       output int elat);
    eerr = (a[1:0] != 2'b00);
    elat = eerr ? 1 : MEM_LAT + 1;
    erd  = (eerr || we) ? 32'd0 : ref_mem[a[6:2]];
    if (we && !eerr) ref_mem[a[6:2]] = wd;
  endtask

  typedef struct {
    bit          port;
    bit          we;
    logic [6:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    bit          exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs [11];

  initial begin
    logic [31:0] erd;
    bit eerr;
    int elat;
    int n_cd, dbg_lat, starve_pk, starve_end;
    int cd_cyc [3];
    logic [31:0] d_rd, c_rd;

    cpu_if.req = 0; cpu_if.we = 0; cpu_if.addr = '0; cpu_if.wdata = '0;
    dbg_if.req = 0; dbg_if.we = 0; dbg_if.addr = '0; dbg_if.wdata = '0;

    vecs[0]  = '{0, 1, 7'h08, 32'h11223344, 32'h0, 0, 3};
    vecs[1]  = '{0, 0, 7'h08, 32'h0, 32'h11223344, 0, 3};
    vecs[2]  = '{0, 1, 7'h64, 32'hDEADBEEF, 32'h0, 0, 3};
    vecs[3]  = '{1, 0, 7'h64, 32'h0, 32'hDEADBEEF, 0, 3};
    vecs[4]  = '{0, 0, 7'h0A, 32'h0, 32'h0, 1, 1};
    vecs[5]  = '{1, 1, 7'h7E, 32'h12345678, 32'h0, 1, 1};
    vecs[6]  = '{1, 1, 7'h7C, 32'hCAFEF00D, 32'h0, 0, 3};
    vecs[7]  = '{0, 0, 7'h7C, 32'h0, 32'hCAFEF00D, 0, 3};
    vecs[8]  = '{1, 0, 7'h03, 32'h0, 32'h0, 1, 1};
    vecs[9]  = '{0, 1, 7'h01, 32'hFFFFFFFF, 32'h0, 1, 1};
    vecs[10] = '{0, 0, 7'h00, 32'h0, pat(0), 0, 3};

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cpu_done", 32'(cpu_if.done), 0);
    chk("rst_dbg_done", 32'(dbg_if.done), 0);
    chk("rst_mem_re", 32'(mem_if.re), 0);
    chk("rst_mem_we", 32'(mem_if.we), 0);
    chk("rst_mem_addr", 32'(mem_if.addr), 0);
    chk("rst_cpu_stall", 32'(cpu_stall), 0);
    chk("rst_state", 32'(dut.state_q), 32'(IDLE));
    chk("rst_starve", 32'(dut.u_starve.cnt_q), 0);
`ifdef DMEM_ARB_PERF_EN
    chk("rst_perf_stall", perf_stall, 0);
    chk("rst_perf_dbg", 32'(perf_dbg), 0);
`endif
    reset = 1'b0;

    // fill every word through DBG
    for (int i = 0; i < 32; i++) begin
      model(1, 7'(i * 4), pat(i), erd, eerr, elat);
      run_one(1, 1, 7'(i * 4), pat(i));
      check_one("fill", 1, 1, 7'(i * 4), pat(i), erd, eerr, elat);
    end

    // directed vector table
    for (int i = 0; i < 11; i++) begin
      model(vecs[i].we, vecs[i].addr, vecs[i].wdata, erd, eerr, elat);
      run_one(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata);
      check_one($sformatf("vec%0d", i), vecs[i].port, vecs[i].we,
                vecs[i].addr, vecs[i].wdata, vecs[i].exp_rd,
                vecs[i].exp_err, vecs[i].exp_lat);
    end

    // simultaneous requests: CPU first, DBG one full access later
    xfer2(1, 0, 7'h08, 0, 1, 0, 7'h64, 0);
    chk("both_cpu_lat", r_lat[0], 3);
    chk("both_dbg_lat", r_lat[1], 3 + 4);
    chk("both_cpu_rd", r_rd[0], 32'h11223344);
    chk("both_dbg_rd", r_rd[1], 32'hDEADBEEF);

    // CPU hammering while DBG waits: DBG forced in after 8 wait cycles
    @(negedge clk);
    cpu_if.req = 1; cpu_if.we = 0; cpu_if.addr = 7'h08;
    dbg_if.req = 1; dbg_if.we = 0; dbg_if.addr = 7'h64;
    n_cd = 0; dbg_lat = 0; starve_pk = -1; starve_end = -1;
    cd_cyc = '{0, 0, 0}; d_rd = '0; c_rd = '0;
    for (int k = 1; k <= 30 && !(n_cd >= 3 && dbg_lat != 0); k++) begin
      @(negedge clk);
      if (k == 8) starve_pk = 32'(dut.u_starve.cnt_q);
      if (cpu_if.done) begin
        if (n_cd < 3) cd_cyc[n_cd] = k;
        c_rd = cpu_if.rdata;
        n_cd++;
        if (n_cd == 3) cpu_if.req = 0;
      end
      if (dbg_if.done) begin
        dbg_lat = k; d_rd = dbg_if.rdata; dbg_if.req = 0;
        starve_end = 32'(dut.u_starve.cnt_q);
      end
    end
    cpu_if.req = 0; dbg_if.req = 0;
    chk("starve_cpu_done0", cd_cyc[0], 3);
    chk("starve_cpu_done1", cd_cyc[1], 7);
    chk("starve_peak", starve_pk, STARVE_MAX);
    chk("starve_dbg_done", dbg_lat, 11);
    chk("starve_cpu_done2", cd_cyc[2], 15);
    chk("starve_cleared", starve_end, 0);
    chk("starve_dbg_rd", d_rd, 32'hDEADBEEF);
    chk("starve_cpu_rd", c_rd, 32'h11223344);

    // reset in the first ACC cycle of a store
    @(negedge clk);
    cpu_if.req = 1; cpu_if.we = 1;
    cpu_if.addr = 7'h10; cpu_if.wdata = 32'h55AA55AA;
    @(negedge clk);
    chk("rst_mid_state_acc", 32'(dut.state_q), 32'(ACC));
    chk("rst_mid_we_early", 32'(mem_if.we), 0);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_state", 32'(dut.state_q), 32'(IDLE));
    chk("rst_mid_we", 32'(mem_if.we), 0);
    chk("rst_mid_re", 32'(mem_if.re), 0);
    chk("rst_mid_done", 32'(cpu_if.done), 0);
`ifdef DMEM_ARB_PERF_EN
    chk("rst_mid_perf_stall", perf_stall, 0);
    chk("rst_mid_perf_dbg", 32'(perf_dbg), 0);
`endif
    reset = 1'b0; cpu_if.req = 0;
    run_one(0, 0, 7'h10, 0);
    check_one("rst_mid_nowrite", 0, 0, 7'h10, 0, pat(4), 0, 3);

    // random single-port traffic against the model
    for (int i = 0; i < 40; i++) begin
      bit p, w;
      logic [6:0] a;
      logic [31:0] wd;
      p = 1'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      a = {5'($urandom_range(0, 31)), 2'b00};
      if ($urandom_range(0, 4) == 0) a[1:0] = 2'($urandom_range(1, 3));
      wd = $urandom;
      model(w, a, wd, erd, eerr, elat);
      run_one(p, w, a, wd);
      check_one($sformatf("rnd%0d", i), p, w, a, wd, erd, eerr, elat);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
